// File: rtl/pwl_seq_pkg.sv
// Shared types and default constants for the PWL generator load/run sequencer.
package pwl_seq_pkg;

  localparam int DEF_CNT_WIDTH      = 32;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOADED = 3'd4,
    ST_RUN    = 3'd5
  } state_t;

endpackage

// File: rtl/pwl_seq_watchdog.sv
// LOAD-phase watchdog: down-counter reloaded on restart or while disabled,
// expired when it has sat at zero for a full enabled cycle without a restart.
module pwl_seq_watchdog
  import pwl_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (!enable || restart) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired = enable && !restart && (cnt_q == '0);

endmodule

// File: rtl/pwl_sequencer.sv
// Load/run sequencer for the PWL waveform generator and its DAC.
// Define PWL_SEQ_TIMEOUT_EN to compile in the LOAD-phase DMA watchdog.
//
// state  | meaning
// IDLE   | nothing loaded, waiting for cmd_load
// HALT   | one-cycle generator halt before a new load
// LOAD   | DMA streaming the wave into the generator
// SETTLE | post-dma_done settle time
// LOADED | wave valid, waiting for cmd_run
// RUN    | generator playing, counting delivered batches
module pwl_sequencer
  import pwl_seq_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_load,
  input  logic                 cmd_run,
  input  logic                 cmd_stop,
  input  logic [CNT_WIDTH-1:0] run_batches,
  input  logic                 dma_valid,
  input  logic                 dma_ready,
  input  logic                 dma_done,
  input  logic                 gen_valid_batch,
  input  logic                 dac0_rdy,
  output logic                 gen_halt,
  output logic                 gen_run,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] batches_sent,
  output logic                 loaded,
  output logic                 busy,
  output logic                 run_done,
  output logic                 err_timeout,
  output logic                 err_cmd
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_nxt;
  logic                   halt_q, halt_nxt;
  logic                   run_q, run_nxt;
  logic                   loaded_q, loaded_nxt;
  logic                   run_done_q, run_done_nxt;
  logic                   err_cmd_q, err_cmd_nxt;
  logic                   err_to_q, err_to_nxt;
  logic [CNT_WIDTH-1:0]   sent_q, sent_nxt;
  logic [CNT_WIDTH-1:0]   run_n_q, run_n_nxt;
  logic [SW-1:0]          settle_q, settle_nxt;

  logic win_stop, win_load, win_run;
  logic run_hit, count_en;
  logic wd_expired;

  // Only the highest-priority command of a coincident set is acted on.
  assign win_stop = cmd_stop;
  assign win_load = cmd_load & ~cmd_stop;
  assign win_run  = cmd_run & ~cmd_stop & ~cmd_load;

  // Hitting the target is seen one cycle after the final increment, which
  // holds gen_run for one extra cycle and freezes the count meanwhile.
  assign run_hit  = (run_n_q != '0) && (sent_q == run_n_q);
  assign count_en = gen_valid_batch & dac0_rdy & ~run_hit & ~(&sent_q);

`ifdef PWL_SEQ_TIMEOUT_EN
  pwl_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart((dma_valid & dma_ready) | dma_done),
    .enable (state_q == ST_LOAD),
    .expired(wd_expired)
  );
`else
  logic unused_wd;
  assign unused_wd  = dma_valid ^ dma_ready ^ (TIMEOUT_CYCLES == 0);
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      halt_q     <= 1'b0;
      run_q      <= 1'b0;
      loaded_q   <= 1'b0;
      run_done_q <= 1'b0;
      err_cmd_q  <= 1'b0;
      err_to_q   <= 1'b0;
      sent_q     <= '0;
      run_n_q    <= '0;
      settle_q   <= SETTLE_RELOAD;
    end else begin
      state_q    <= state_nxt;
      halt_q     <= halt_nxt;
      run_q      <= run_nxt;
      loaded_q   <= loaded_nxt;
      run_done_q <= run_done_nxt;
      err_cmd_q  <= err_cmd_nxt;
      err_to_q   <= err_to_nxt;
      sent_q     <= sent_nxt;
      run_n_q    <= run_n_nxt;
      settle_q   <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    halt_nxt     = 1'b0;
    run_done_nxt = 1'b0;
    err_cmd_nxt  = 1'b0;
    loaded_nxt   = loaded_q;
    err_to_nxt   = err_to_q;
    sent_nxt     = sent_q;
    run_n_nxt    = run_n_q;
    settle_nxt   = settle_q;

    case (state_q)
      ST_IDLE, ST_LOADED: begin
        if (win_load) begin
          state_nxt  = ST_HALT;
          halt_nxt   = 1'b1;
          loaded_nxt = 1'b0;
          err_to_nxt = 1'b0;
        end else if (win_run) begin
          if (state_q == ST_LOADED) begin
            state_nxt = ST_RUN;
            run_n_nxt = run_batches;
            sent_nxt  = '0;
          end else begin
            err_cmd_nxt = 1'b1;
          end
        end
      end

      ST_HALT: begin
        if (win_stop) begin
          state_nxt = ST_IDLE;
          halt_nxt  = 1'b1;
        end else begin
          err_cmd_nxt = win_load | win_run;
          state_nxt   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (win_stop) begin
          state_nxt  = ST_IDLE;
          halt_nxt   = 1'b1;
          loaded_nxt = 1'b0;
        end else begin
          err_cmd_nxt = win_load | win_run;
          if (dma_done) begin
            state_nxt  = ST_SETTLE;
            settle_nxt = SETTLE_RELOAD;
          end else if (wd_expired) begin
            state_nxt  = ST_IDLE;
            halt_nxt   = 1'b1;
            err_to_nxt = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (win_stop) begin
          state_nxt  = ST_IDLE;
          halt_nxt   = 1'b1;
          loaded_nxt = 1'b0;
        end else begin
          err_cmd_nxt = win_load | win_run;
          if (settle_q == '0) begin
            state_nxt  = ST_LOADED;
            loaded_nxt = 1'b1;
          end else begin
            settle_nxt = settle_q - SW'(1);
          end
        end
      end

      ST_RUN: begin
        if (count_en) begin
          sent_nxt = sent_q + CNT_WIDTH'(1);
        end
        if (win_stop) begin
          state_nxt = ST_LOADED;
        end else begin
          err_cmd_nxt = win_load | win_run;
          if (run_hit) begin
            state_nxt    = ST_LOADED;
            run_done_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    run_nxt = (state_nxt == ST_RUN);
  end

  assign gen_halt     = halt_q;
  assign gen_run      = run_q;
  assign state        = state_q;
  assign batches_sent = sent_q;
  assign loaded       = loaded_q;
  assign run_done     = run_done_q;
  assign err_cmd      = err_cmd_q;
  assign err_timeout  = err_to_q;
  assign busy         = (state_q == ST_HALT) || (state_q == ST_LOAD) ||
                        (state_q == ST_SETTLE) || (state_q == ST_RUN);

endmodule

// File: tb/tb_pwl_sequencer.sv
// Self-checking bench for pwl_sequencer: vector table, corner sequences, and
// randomized traffic against a cycle-level behavioural model.
module tb_pwl_sequencer;
  import pwl_seq_pkg::*;

  localparam int CW   = 8;
  localparam int SETL = 4;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          cmd_load, cmd_run, cmd_stop;
  logic [CW-1:0] run_batches;
  logic          dma_valid, dma_ready, dma_done;
  logic          gen_valid_batch, dac0_rdy;
  logic          gen_halt, gen_run, loaded, busy, run_done, err_timeout, err_cmd;
  logic [2:0]    state;
  logic [CW-1:0] batches_sent;

  int n_cmp = 0;
  int n_bad = 0;

  pwl_sequencer #(
    .CNT_WIDTH(CW), .SETTLE_CYCLES(SETL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .run_batches(run_batches),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_done(dma_done),
    .gen_valid_batch(gen_valid_batch), .dac0_rdy(dac0_rdy),
    .gen_halt(gen_halt), .gen_run(gen_run), .state(state),
    .batches_sent(batches_sent), .loaded(loaded), .busy(busy),
    .run_done(run_done), .err_timeout(err_timeout), .err_cmd(err_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit ld, rn, sp, hs, dn, bv;
    int nb, rep;
    logic [2:0] st;
    bit hlt, run, ldd, rd, ec;
    int bs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit ld, bit rn, bit sp, bit hs, bit dn, bit bv, int nb, int rep,
                             state_t st, bit hlt, bit run, bit ldd, bit rd, bit ec, int bs);
    vec_t r;
    r.ld = ld; r.rn = rn; r.sp = sp; r.hs = hs; r.dn = dn; r.bv = bv;
    r.nb = nb; r.rep = rep; r.st = st;
    r.hlt = hlt; r.run = run; r.ldd = ldd; r.rd = rd; r.ec = ec; r.bs = bs;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input bit hlt, input bit run,
                         input bit ldd, input bit rd, input bit ec, input bit eto, input int bs);
    bit bz;
    bz = (st == ST_HALT) || (st == ST_LOAD) || (st == ST_SETTLE) || (st == ST_RUN);
    chk({tag, ".state"},    32'(state),        32'(st));
    chk({tag, ".gen_halt"}, 32'(gen_halt),     32'(hlt));
    chk({tag, ".gen_run"},  32'(gen_run),      32'(run));
    chk({tag, ".loaded"},   32'(loaded),       32'(ldd));
    chk({tag, ".run_done"}, 32'(run_done),     32'(rd));
    chk({tag, ".err_cmd"},  32'(err_cmd),      32'(ec));
    chk({tag, ".err_to"},   32'(err_timeout),  32'(eto));
    chk({tag, ".busy"},     32'(busy),         32'(bz));
    chk({tag, ".batches"},  32'(batches_sent), 32'(bs));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit ld, input bit rn, input bit sp, input bit hs,
                        input bit dn, input bit bv, input int nb);
    cmd_load = ld; cmd_run = rn; cmd_stop = sp;
    dma_valid = hs; dma_ready = hs; dma_done = dn;
    gen_valid_batch = bv; dac0_rdy = bv;
    run_batches = CW'(nb);
  endtask

  task automatic do_load();
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (SETL) tick();
    chk("do_load.loaded", 32'(loaded), 32'd1);
  endtask

  // ---------------- behavioural reference model ----------------
  state_t m_st;
  bit     m_halt, m_rd, m_ec, m_loaded, m_eto;
  int     m_sent, m_n, m_settle, m_idle;

  task automatic model_reset();
    m_st = ST_IDLE; m_halt = 0; m_rd = 0; m_ec = 0; m_loaded = 0; m_eto = 0;
    m_sent = 0; m_n = 0; m_settle = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit ld, input bit rn, input bit sp, input bit hs,
                            input bit dn, input bit gb, input int nb);
    bit w_ld, w_rn, hit;
    w_ld = ld && !sp;
    w_rn = rn && !sp && !ld;
    m_halt = 0; m_rd = 0; m_ec = 0;
    case (m_st)
      ST_IDLE, ST_LOADED: begin
        if (w_ld) begin
          m_st = ST_HALT; m_halt = 1; m_loaded = 0; m_eto = 0;
        end else if (w_rn) begin
          if (m_st == ST_LOADED) begin
            m_st = ST_RUN; m_n = nb; m_sent = 0;
          end else m_ec = 1;
        end
      end
      ST_HALT: begin
        if (sp) begin m_st = ST_IDLE; m_halt = 1; end
        else begin m_ec = w_ld || w_rn; m_st = ST_LOAD; m_idle = 0; end
      end
      ST_LOAD: begin
        if (sp) begin m_st = ST_IDLE; m_halt = 1; m_loaded = 0; end
        else begin
          m_ec = w_ld || w_rn;
          if (dn) begin m_st = ST_SETTLE; m_settle = 0; end
          else begin
            m_idle = hs ? 0 : m_idle + 1;
`ifdef PWL_SEQ_TIMEOUT_EN
            if (m_idle >= TO) begin m_st = ST_IDLE; m_halt = 1; m_eto = 1; end
`endif
          end
        end
      end
      ST_SETTLE: begin
        if (sp) begin m_st = ST_IDLE; m_halt = 1; m_loaded = 0; end
        else begin
          m_ec = w_ld || w_rn;
          m_settle++;
          if (m_settle == SETL) begin m_st = ST_LOADED; m_loaded = 1; end
        end
      end
      ST_RUN: begin
        hit = (m_n != 0) && (m_sent == m_n);
        if (gb && !hit && m_sent < MAXC) m_sent++;
        if (sp) m_st = ST_LOADED;
        else begin
          m_ec = w_ld || w_rn;
          if (hit) begin m_st = ST_LOADED; m_rd = 1; end
        end
      end
      default: m_st = ST_IDLE;
    endcase
  endtask

  initial begin
    int rd_seen, k;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_all("reset", ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // ---- vector table ----
    tbl.push_back(v(0,1,0,0,0,0,0,1,  ST_IDLE,  0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_IDLE,  0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,0,1,  ST_IDLE,  0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,1,  ST_HALT,  1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_LOAD,  0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,10, ST_LOAD,  0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,1,  ST_LOAD,  0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,1,0,0,1,  ST_SETTLE,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,3,  ST_SETTLE,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_LOADED,0,0,1,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0,1,  ST_LOADED,0,0,1,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,3,1,  ST_RUN,   0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,0,1,  ST_RUN,   0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,0,0,1,0,1,  ST_RUN,   0,1,1,0,0,2));
    tbl.push_back(v(0,0,0,0,0,1,0,1,  ST_RUN,   0,1,1,0,0,3));
    tbl.push_back(v(0,0,0,0,0,1,0,1,  ST_LOADED,0,0,1,1,0,3));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_LOADED,0,0,1,0,0,3));
    tbl.push_back(v(0,1,0,0,0,0,2,1,  ST_RUN,   0,1,1,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,1,  ST_RUN,   0,1,1,0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0,1,  ST_RUN,   0,1,1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,0,0,1,  ST_LOADED,0,0,1,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0,1,  ST_HALT,  1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_LOAD,  0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,0,1,  ST_IDLE,  1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,  ST_IDLE,  0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        set_in(tbl[i].ld, tbl[i].rn, tbl[i].sp, tbl[i].hs, tbl[i].dn, tbl[i].bv, tbl[i].nb);
        tick();
        chk_all($sformatf("tbl%0d", i), tbl[i].st, tbl[i].hlt, tbl[i].run,
                tbl[i].ldd, tbl[i].rd, tbl[i].ec, 0, tbl[i].bs);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0);

    // ---- open run: 100 batches then stop ----
    do_load();
    set_in(0, 1, 0, 0, 0, 0, 0); tick();
    rd_seen = 0;
    set_in(0, 0, 0, 0, 0, 1, 0);
    repeat (100) begin tick(); rd_seen += run_done; end
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); rd_seen += run_done;
    chk("open.batches", 32'(batches_sent), 32'd100);
    chk("open.gen_run_before_stop", 32'(gen_run), 32'd1);
    set_in(0, 0, 1, 0, 0, 0, 0); tick(); rd_seen += run_done;
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("open.gen_run_after_stop", 32'(gen_run), 32'd0);
    chk("open.state", 32'(state), 32'(ST_LOADED));
    tick(); rd_seen += run_done;
    chk("open.no_run_done", 32'(rd_seen), 32'd0);

    // ---- saturation of batches_sent ----
    set_in(0, 1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0);
    repeat (MAXC + 20) tick();
    chk("sat.batches", 32'(batches_sent), 32'(MAXC));
    chk("sat.gen_run", 32'(gen_run), 32'd1);
    set_in(0, 0, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);

    // ---- asynchronous reset mid-run ----
    set_in(0, 1, 0, 0, 0, 0, 5); tick();
    set_in(0, 0, 0, 0, 0, 1, 0); tick(); tick();
    chk("rstrun.batches_pre", 32'(batches_sent), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_all("rstrun", ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 1, 0, 0, 0, 0, 3); tick();
    chk_all("rstrun.first_cmd", ST_IDLE, 0, 0, 0, 0, 1, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); tick();

    // ---- LOAD watchdog ----
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef PWL_SEQ_TIMEOUT_EN
    k = 0;
    while (k < 3 * TO && !err_timeout) begin tick(); k++; end
    chk("wd.latency", 32'(k), 32'(TO));
    chk_all("wd.expire", ST_IDLE, 1, 0, 0, 0, 0, 1, 0);
    tick();
    chk_all("wd.sticky", ST_IDLE, 0, 0, 0, 0, 0, 1, 0);
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    chk_all("wd.clear", ST_HALT, 1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
`else
    k = 0;
    repeat (3 * TO) begin tick(); k++; end
    chk_all("wd.off", ST_LOAD, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_in(0, 0, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick();

    // ---- randomized traffic against the model ----
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit ld, rn, sp, dv, dr, dn, gv, dk;
      int nb;
      ld = ($urandom_range(0, 99) < 4);
      rn = ($urandom_range(0, 99) < 8);
      sp = ($urandom_range(0, 99) < 3);
      dv = ($urandom_range(0, 99) < 45);
      dr = ($urandom_range(0, 99) < 50);
      dn = ($urandom_range(0, 99) < 3);
      gv = ($urandom_range(0, 99) < 75);
      dk = ($urandom_range(0, 99) < 75);
      nb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      cmd_load = ld; cmd_run = rn; cmd_stop = sp;
      dma_valid = dv; dma_ready = dr; dma_done = dn;
      gen_valid_batch = gv; dac0_rdy = dk;
      run_batches = CW'(nb);
      model_step(ld, rn, sp, dv && dr, dn, gv && dk, nb);
      tick();
      chk_all("rnd", m_st, m_halt, (m_st == ST_RUN), m_loaded, m_rd, m_ec, m_eto, m_sent);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
